// File: rtl/line_buffer_reader_if.sv
// Pixel stream between the line buffer reader and the downstream pixel writer.
//   x, y       coordinate of the presented pixel (driven by the reader)
//   pix_valid  x/y hold a set pixel (driven by the reader)
//   pix_ready  downstream accepts when high together with pix_valid
// The master modport is the reader side. The slave modport is the writer side.
interface line_buffer_reader_if #(
  parameter int XW = 6,
  parameter int YW = 7
);
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          pix_valid;
  logic          pix_ready;

  modport master (output x, output y, output pix_valid, input pix_ready);
  modport slave  (input x, input y, input pix_valid, output pix_ready);
endinterface

// File: rtl/line_buffer_reader.sv
// line_buffer_reader: read-side companion of the line rasteriser.
// On start it snapshots the WIDTH x HEIGHT bitmap. It then scans the snapshot
// in ascending index order, so y runs fastest and x follows. It presents the
// (x,y) of every set pixel on a valid/ready stream.
//   clk          system clock, rising edge
//   n_rst        asynchronous active-low reset
//   start        begin a scan; only honoured while idle
//   line_buffer  bitmap, bit HEIGHT*x+y is pixel (x,y)
//   pix_bus      x / y / pix_valid out, pix_ready in (master modport)
//   busy         high while scanning or presenting a pixel
//   pixel_count  pixels accepted in the current or most recent scan
//   done         one-cycle pulse when a scan completes
module line_buffer_reader #(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 65,
  parameter int XW     = 6,
  parameter int YW     = 7,
  parameter int CW     = 13
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    start,
  input  logic [WIDTH*HEIGHT-1:0] line_buffer,
  line_buffer_reader_if.master    pix_bus,
  output logic                    busy,
  output logic [CW-1:0]           pixel_count,
  output logic                    done
);

  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int IW    = $clog2(TOTAL);
  localparam logic [IW-1:0] LAST_IDX = IW'(TOTAL - 1);
  localparam logic [YW-1:0] LAST_Y   = YW'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, SCAN, OUT, DONE} state_e;

  state_e            state_q, state_d;
  logic [TOTAL-1:0]  snap_q, snap_d;
  logic [IW-1:0]     idx_q, idx_d;
  // Scan position as coordinates. These track idx_q so that no divider is needed.
  logic [XW-1:0]     sx_q, sx_d;
  logic [YW-1:0]     sy_q, sy_d;
  // Presented coordinate. It only changes when a new pixel is loaded.
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic              valid_q, valid_d;
  logic [CW-1:0]     count_q, count_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              step;

  always_comb begin
    // NOTE: every next-state value starts from its hold value before the case,
    // so no path can leave a signal unassigned and infer a latch.
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    x_d     = x_q;
    y_d     = y_q;
    valid_d = valid_q;
    count_d = count_q;
    step    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          snap_d  = line_buffer;
          idx_d   = '0;
          sx_d    = '0;
          sy_d    = '0;
          count_d = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (snap_q[idx_q]) begin
          x_d     = sx_q;
          y_d     = sy_q;
          valid_d = 1'b1;
          state_d = OUT;
        end else if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          step = 1'b1;
        end
      end
      OUT: begin
        // pix_valid is high throughout OUT, so pix_ready alone completes the handshake.
        if (pix_bus.pix_ready) begin
          count_d = count_q + CW'(1);
          valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            step    = 1'b1;
            state_d = SCAN;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Advance to the next bit. y wraps at the column end and then x steps.
    if (step) begin
      idx_d = idx_q + IW'(1);
      if (sy_q == LAST_Y) begin
        sy_d = '0;
        sx_d = sx_q + XW'(1);
      end else begin
        sy_d = sy_q + YW'(1);
      end
    end

    // busy and done are registered. They are decoded from the state being entered.
    busy_d = (state_d == SCAN) || (state_d == OUT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      // NOTE: the snapshot is cleared on reset like any other register, so
      // nothing written before reset can leak into a later scan.
      snap_q  <= '0;
      idx_q   <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments, so every register
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      x_q     <= x_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign pix_bus.x         = x_q;
  assign pix_bus.y         = y_q;
  assign pix_bus.pix_valid = valid_q;
  assign busy              = busy_q;
  assign pixel_count       = count_q;
  assign done              = done_q;

endmodule

// File: tb/tb_line_buffer_reader.sv
// Self-checking bench for line_buffer_reader. An event-level model predicts
// which pixels must appear, when, and what busy, done and pixel_count show on
// every cycle. Directed scenarios add literal expectations on top.
module tb_line_buffer_reader;

  localparam int WIDTH  = 64;
  localparam int HEIGHT = 65;
  localparam int XW     = 6;
  localparam int YW     = 7;
  localparam int CW     = 13;
  localparam int TOTAL  = WIDTH * HEIGHT;

  logic             clk = 1'b0;
  logic             n_rst;
  logic             start;
  logic [TOTAL-1:0] lb;
  logic             busy;
  logic [CW-1:0]    pixel_count;
  logic             done;

  line_buffer_reader_if #(.XW(XW), .YW(YW)) bus ();

  line_buffer_reader #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .XW(XW), .YW(YW), .CW(CW)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start       (start),
    .line_buffer (lb),
    .pix_bus     (bus),
    .busy        (busy),
    .pixel_count (pixel_count),
    .done        (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Accepted transfers, recorded from the bus.
  int acc_x[$];
  int acc_y[$];
  int hs_cyc;
  always @(posedge clk) begin
    if (n_rst && bus.pix_valid && bus.pix_ready) begin
      acc_x.push_back(int'(bus.x));
      acc_y.push_back(int'(bus.y));
      hs_cyc = cyc;
    end
  end

  // Event-level model. After each scan event, the next event is the next set
  // index e. Until then the scan spends (e - prev) cycles on clear bits. The
  // completion event has e = TOTAL-1, and zero remaining cycles means done follows at once.
  typedef enum {M_IDLE, M_GAP, M_WAIT, M_DONE} m_phase_e;
  m_phase_e         m_phase = M_IDLE;
  int               m_list[$];
  int               m_prev;
  int               m_left;
  int               m_count = 0;
  logic [TOTAL-1:0] m_snap;

  logic             s_rst   = 1'b0;
  logic             s_start = 1'b0;
  logic             s_ready = 1'b0;
  logic [TOTAL-1:0] s_lb    = '0;

  int  done_pulses = 0;
  int  done_cyc    = 0;
  int  busy_cyc    = 0;
  bit  done_seen   = 1'b0;

  task automatic m_schedule();
    int e;
    e = (m_list.size() > 0) ? m_list[0] : TOTAL - 1;
    m_left = e - m_prev;
    if (m_left == 0) m_phase = M_DONE;
    else             m_phase = M_GAP;
  endtask

  always @(negedge clk) begin
    // Apply the edge that just passed, using the inputs it sampled.
    if (!s_rst) begin
      m_phase = M_IDLE;
      m_count = 0;
      m_list.delete();
    end else begin
      case (m_phase)
        M_IDLE: if (s_start) begin
          m_snap = s_lb;
          m_list.delete();
          for (int i = 0; i < TOTAL; i++) if (m_snap[i]) m_list.push_back(i);
          m_prev  = -1;
          m_count = 0;
          m_schedule();
        end
        M_GAP: begin
          m_left--;
          if (m_left == 0) m_phase = (m_list.size() > 0) ? M_WAIT : M_DONE;
        end
        M_WAIT: if (s_ready) begin
          m_count++;
          m_prev = m_list.pop_front();
          m_schedule();
        end
        M_DONE: m_phase = M_IDLE;
        default: m_phase = M_IDLE;
      endcase
    end

    if (!n_rst) begin
      check("rst_valid", longint'(bus.pix_valid), 0);
      check("rst_busy",  longint'(busy), 0);
      check("rst_done",  longint'(done), 0);
      check("rst_count", longint'(pixel_count), 0);
      check("rst_x",     longint'(bus.x), 0);
      check("rst_y",     longint'(bus.y), 0);
    end else begin
      check("busy",  longint'(busy), longint'(m_phase == M_GAP || m_phase == M_WAIT));
      check("valid", longint'(bus.pix_valid), longint'(m_phase == M_WAIT));
      check("done",  longint'(done), longint'(m_phase == M_DONE));
      check("count", longint'(pixel_count), longint'(m_count));
      if (m_phase == M_WAIT) begin
        check("x", longint'(bus.x), longint'(m_list[0] / HEIGHT));
        check("y", longint'(bus.y), longint'(m_list[0] % HEIGHT));
      end
    end

    if (done) begin
      done_pulses++;
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
    if (busy) busy_cyc++;

    s_rst   = n_rst;
    s_start = start;
    s_ready = bus.pix_ready;
    s_lb    = lb;
  end

  // Ready patterns: 0 always ready, 1 toggle each cycle, 2 never ready.
  int rdy_mode = 0;
  int t0;

  task automatic step();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: bus.pix_ready = 1'b1;
      1: bus.pix_ready = ~bus.pix_ready;
      default: bus.pix_ready = 1'b0;
    endcase
  endtask

  task automatic do_start();
    step();
    start = 1'b1;
    t0    = cyc;
    acc_x.delete();
    acc_y.delete();
    busy_cyc    = 0;
    done_pulses = 0;
    done_seen   = 1'b0;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done_seen && n < 10000) begin
      step();
      n++;
    end
    check(name, longint'(done_seen), 1);
  endtask

  initial begin
    n_rst = 1'b0;
    start = 1'b0;
    lb    = '0;
    bus.pix_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    step();

    // 1: empty bitmap, full-length scan.
    lb = '0;
    rdy_mode = 0;
    do_start();
    wait_done("t1_done_seen");
    check("t1_done_cycle", longint'(done_cyc - t0), 4161);
    check("t1_busy_cycles", longint'(busy_cyc), 4160);
    check("t1_transfers", longint'(acc_x.size()), 0);
    check("t1_count", longint'(pixel_count), 0);
    step();

    // 2: single pixel (3,5).
    lb = '0;
    lb[65*3+5] = 1'b1;
    do_start();
    wait_done("t2_done_seen");
    check("t2_transfers", longint'(acc_x.size()), 1);
    check("t2_x", longint'(acc_x[0]), 3);
    check("t2_y", longint'(acc_y[0]), 5);
    check("t2_count", longint'(pixel_count), 1);
    check("t2_done_pulses", longint'(done_pulses), 1);
    step();

    // 3: diagonal with ready toggling.
    lb = '0;
    for (int i = 0; i < 64; i++) lb[65*i+i] = 1'b1;
    rdy_mode = 1;
    do_start();
    wait_done("t3_done_seen");
    check("t3_transfers", longint'(acc_x.size()), 64);
    check("t3_x10", longint'(acc_x[10]), 10);
    check("t3_y10", longint'(acc_y[10]), 10);
    check("t3_x63", longint'(acc_x[63]), 63);
    check("t3_y63", longint'(acc_y[63]), 63);
    check("t3_count", longint'(pixel_count), 64);
    step();

    // 4: first and last bit, completion straight after the final handshake.
    lb = '0;
    lb[0] = 1'b1;
    lb[TOTAL-1] = 1'b1;
    rdy_mode = 0;
    do_start();
    wait_done("t4_done_seen");
    check("t4_transfers", longint'(acc_x.size()), 2);
    check("t4_x0", longint'(acc_x[0]), 0);
    check("t4_y0", longint'(acc_y[0]), 0);
    check("t4_x1", longint'(acc_x[1]), 63);
    check("t4_y1", longint'(acc_y[1]), 64);
    check("t4_done_after_hs", longint'(done_cyc - hs_cyc), 1);
    check("t4_count", longint'(pixel_count), 2);
    step();

    // 5: bitmap flipped and start pulsed mid-scan.
    lb = '0;
    lb[7] = 1'b1;
    lb[300] = 1'b1;
    lb[2000] = 1'b1;
    do_start();
    repeat (500) step();
    lb = ~lb;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("t5_done_seen");
    check("t5_transfers", longint'(acc_x.size()), 3);
    check("t5_x1", longint'(acc_x[1]), 4);
    check("t5_y1", longint'(acc_y[1]), 40);
    check("t5_x2", longint'(acc_x[2]), 30);
    check("t5_y2", longint'(acc_y[2]), 50);
    check("t5_count", longint'(pixel_count), 3);
    check("t5_done_pulses", longint'(done_pulses), 1);
    lb = '0;
    step();

    // 6: reset while a pixel waits on ready, then a clean rescan.
    lb = '0;
    lb[5] = 1'b1;
    lb[70] = 1'b1;
    rdy_mode = 0;
    do_start();
    begin
      int n = 0;
      while (acc_x.size() < 1 && n < 50) begin step(); n++; end
      rdy_mode = 2;
      n = 0;
      while (!bus.pix_valid && n < 200) begin step(); n++; end
    end
    check("t6_reached_out", longint'(bus.pix_valid), 1);
    check("t6_count_before", longint'(pixel_count), 1);
    check("t6_y_before", longint'(bus.y), 5);
    @(posedge clk);
    #1 n_rst = 1'b0;
    #1;
    check("t6_now_valid", longint'(bus.pix_valid), 0);
    check("t6_now_busy", longint'(busy), 0);
    check("t6_now_count", longint'(pixel_count), 0);
    check("t6_now_x", longint'(bus.x), 0);
    check("t6_now_y", longint'(bus.y), 0);
    repeat (3) step();
    check("t6_no_done", longint'(done_pulses), 0);
    #1 n_rst = 1'b1;
    lb = '0;
    lb[4100] = 1'b1;
    rdy_mode = 0;
    step();
    do_start();
    wait_done("t6_done_seen");
    check("t6_transfers", longint'(acc_x.size()), 1);
    check("t6_x", longint'(acc_x[0]), 63);
    check("t6_y", longint'(acc_y[0]), 5);
    check("t6_count", longint'(pixel_count), 1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
